// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared widths, SPI slave FSM state type, SIZE field codes and
//             the SIZE -> significant-bit mask helper.
//  Revision : 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int DWIDTH = 32;   // data field / register width
    localparam int AWIDTH = 8;    // address field width

    // Slave frame decoder states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } slv_state_t;

    // SIZE field codes (1x selects the full data width)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Mask of the significant low bits for a given SIZE code
    function automatic logic [DWIDTH-1:0] size_mask(input logic [1:0] size);
        logic [DWIDTH-1:0] mask;
        mask = '1;
        case (size)
            SZ_BYTE:       mask = {{(DWIDTH-8){1'b0}}, 8'hFF};
            SZ_HALF:       mask = {{(DWIDTH-16){1'b0}}, 16'hFFFF};
            SZ_WORD, 2'b11: mask = '1;
            default:       mask = '1;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_responder_if
//  Purpose  : SPI pins plus the completed-frame report of one slave endpoint.
//             slave modport = endpoint side, master modport = driver side.
//  Revision : 1.0  initial release
// ============================================================================
interface spi_slave_responder_if;
    import spi_pkg::*;

    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              frame_done;
    logic              frame_wr;
    logic [AWIDTH-1:0] frame_addr;
    logic [DWIDTH-1:0] frame_data;
    logic              frame_err;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi,
        output spi_miso, spi_miso_oe,
        output frame_done, frame_wr, frame_addr, frame_data, frame_err
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi,
        input  spi_miso, spi_miso_oe,
        input  frame_done, frame_wr, frame_addr, frame_data, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/spi_slv_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slv_regfile
//  Purpose  : DEPTH x DWIDTH register file, one bit-masked write port and one
//             combinational read port, asynchronously cleared.
//  Revision : 1.0  initial release
// ============================================================================
module spi_slv_regfile
    import spi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              i_we,
    input  wire [AW-1:0]     i_waddr,
    input  wire [DWIDTH-1:0] i_wdata,
    input  wire [DWIDTH-1:0] i_wmask,
    input  wire [AW-1:0]     i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    // Masked write: bits outside i_wmask keep their old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_responder
//  Purpose  : Oversampling SPI mode-0 slave decoding {WR_EN, SIZE, ADDR, DATA}
//             frames into a local register file; reads are returned on MISO.
//  Config   : SPI_SLV_ERR_EN - when defined, frame_err pulses on aborted and
//             over-length frames; otherwise frame_err is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int SYNC_STG = 2
) (
    input  wire clk,
    input  wire rst_n,
    spi_slave_responder_if.slave bus
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2((DWIDTH > AWIDTH) ? DWIDTH : AWIDTH);

    localparam logic [c_CW-1:0] c_CMD_LAST  = c_CW'(2);
    localparam logic [c_CW-1:0] c_ADDR_LAST = c_CW'(AWIDTH - 1);
    localparam logic [c_CW-1:0] c_DATA_LAST = c_CW'(DWIDTH - 1);

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STG-1:0] r_sclk_sync;
    logic [SYNC_STG-1:0] r_cs_sync;
    logic [SYNC_STG-1:0] r_mosi_sync;
    logic                r_sclk_prev;
    logic                r_cs_prev;

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STG-2:0], bus.spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STG-2:0],   bus.spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STG-2:0], bus.spi_mosi};
            r_sclk_prev <= r_sclk_sync[SYNC_STG-1];
            r_cs_prev   <= r_cs_sync[SYNC_STG-1];
        end
    end

    logic w_sclk_s, w_cs_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    assign w_sclk_s    = r_sclk_sync[SYNC_STG-1];
    assign w_cs_s      = r_cs_sync[SYNC_STG-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STG-1];
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_prev;
    assign w_cs_rise   =  w_cs_s   & ~r_cs_prev;
    assign w_cs_fall   = ~w_cs_s   &  r_cs_prev;

    // ------------------------------------------------------------------
    // Frame decoder state
    // ------------------------------------------------------------------
    slv_state_t          r_state;
    logic [c_CW-1:0]     r_bit_cnt;
    logic [DWIDTH-2:0]   r_shift_in;
    logic [DWIDTH-1:0]   r_shift_out;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_fin_data;
    logic                r_done_pend;
    logic                r_miso;
    logic                r_oe;
    logic                r_frame_done;
    logic                r_frame_wr;
    logic [AWIDTH-1:0]   r_frame_addr;
    logic [DWIDTH-1:0]   r_frame_data;
`ifdef SPI_SLV_ERR_EN
    logic                r_frame_err;
    logic                r_extra;
`endif

    // Shift register contents including the bit arriving on this rise
    logic [DWIDTH-1:0]   w_data_word;
    logic [AWIDTH-1:0]   w_addr_word;
    logic [DWIDTH-1:0]   w_wmask;
    logic [DWIDTH-1:0]   w_rdata;
    logic                w_we;
    logic                w_abort;

    assign w_data_word = {r_shift_in, w_mosi_s};
    assign w_addr_word = w_data_word[AWIDTH-1:0];
    assign w_wmask     = size_mask(r_size);
    assign w_we        = (r_state == DATA) && w_sclk_rise && !w_cs_rise &&
                         r_wr && (r_bit_cnt == c_DATA_LAST);
    assign w_abort     = w_cs_rise &&
                         (r_state == CMD || r_state == ADDR || r_state == DATA);

    spi_slv_regfile #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_addr[c_AW-1:0]),
        .i_wdata (w_data_word),
        .i_wmask (w_wmask),
        .i_raddr (w_addr_word[c_AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Frame FSM: field counting, shift in/out, MISO drive and frame report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_shift_in   <= '0;
            r_shift_out  <= '0;
            r_wr         <= 1'b0;
            r_size       <= '0;
            r_addr       <= '0;
            r_fin_data   <= '0;
            r_done_pend  <= 1'b0;
            r_miso       <= 1'b0;
            r_oe         <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_wr   <= 1'b0;
            r_frame_addr <= '0;
            r_frame_data <= '0;
`ifdef SPI_SLV_ERR_EN
            r_frame_err  <= 1'b0;
            r_extra      <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
`ifdef SPI_SLV_ERR_EN
            r_frame_err  <= 1'b0;
`endif
            // Report lags the register update by one cycle
            if (r_done_pend) begin
                r_done_pend  <= 1'b0;
                r_frame_done <= 1'b1;
                r_frame_wr   <= r_wr;
                r_frame_addr <= r_addr;
                r_frame_data <= r_fin_data;
            end

            if (w_abort) begin
                r_state <= IDLE;
                r_oe    <= 1'b0;
                r_miso  <= 1'b0;
`ifdef SPI_SLV_ERR_EN
                r_frame_err <= 1'b1;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= CMD;
                            r_bit_cnt <= '0;
                        end
                    end

                    CMD: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= w_data_word[DWIDTH-2:0];
                            if (r_bit_cnt == c_CMD_LAST) begin
                                r_wr      <= r_shift_in[1];
                                r_size    <= {r_shift_in[0], w_mosi_s};
                                r_state   <= ADDR;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_CW'(1);
                            end
                        end
                    end

                    ADDR: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= w_data_word[DWIDTH-2:0];
                            if (r_bit_cnt == c_ADDR_LAST) begin
                                r_addr    <= w_addr_word;
                                r_state   <= DATA;
                                r_bit_cnt <= '0;
                                // Read data is frozen here; later writes cannot race it
                                if (!r_wr) begin
                                    r_shift_out <= w_rdata & w_wmask;
                                    r_fin_data  <= w_rdata & w_wmask;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_CW'(1);
                            end
                        end
                    end

                    DATA: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= w_data_word[DWIDTH-2:0];
                            if (r_bit_cnt == c_DATA_LAST) begin
                                r_state     <= DONE;
                                r_done_pend <= 1'b1;
                                if (r_wr) begin
                                    r_fin_data <= w_data_word & w_wmask;
                                end
`ifdef SPI_SLV_ERR_EN
                                r_extra <= 1'b0;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_CW'(1);
                            end
                        end else if (w_sclk_fall && !r_wr) begin
                            r_oe        <= 1'b1;
                            r_miso      <= r_shift_out[DWIDTH-1];
                            r_shift_out <= {r_shift_out[DWIDTH-2:0], 1'b0};
                        end
                    end

                    DONE: begin
                        if (w_cs_rise) begin
                            r_state <= IDLE;
                            r_oe    <= 1'b0;
                            r_miso  <= 1'b0;
                        end
`ifdef SPI_SLV_ERR_EN
                        else if (w_sclk_rise && !r_extra) begin
                            r_extra     <= 1'b1;
                            r_frame_err <= 1'b1;
                        end
`endif
                    end

                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.spi_miso    = r_miso & r_oe;
    assign bus.spi_miso_oe = r_oe;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_wr    = r_frame_wr;
    assign bus.frame_addr  = r_frame_addr;
    assign bus.frame_data  = r_frame_data;
`ifdef SPI_SLV_ERR_EN
    assign bus.frame_err   = r_frame_err;
`else
    assign bus.frame_err   = 1'b0;
`endif

endmodule
`default_nettype wire
